// File: rtl/airlock_pkg.sv
// Shared airlock encodings: interlock door commands, door status and actuator states.
// Used by both the interlock controller and the lock actuator.
package airlock_pkg;

   localparam logic [2:0] DOOR_COMMAND_IDLE         = 3'b000;
   localparam logic [2:0] DOOR_COMMAND_CLOSE_INNER  = 3'b001;
   localparam logic [2:0] DOOR_COMMAND_OPEN_INNER   = 3'b010;
   localparam logic [2:0] DOOR_COMMAND_CLOSE_OUTER  = 3'b011;
   localparam logic [2:0] DOOR_COMMAND_OPEN_OUTER   = 3'b100;
   localparam logic [2:0] DOOR_COMMAND_DEPRESSURIZE = 3'b101;
   localparam logic [2:0] DOOR_COMMAND_PRESSURIZE   = 3'b110;
   localparam logic [2:0] DOOR_COMMAND_RESERVED     = 3'b111;

   localparam logic [1:0] DOORS_CLOSED      = 2'b00;
   localparam logic [1:0] INNER_DOOR_OPENED = 2'b01;
   localparam logic [1:0] OUTER_DOOR_OPENED = 2'b10;

   typedef enum logic [2:0] {
      StIdle,
      StInnerOpening,
      StInnerClosing,
      StOuterOpening,
      StOuterClosing,
      StPumpDown,
      StPumpUp
   } act_state_e;

endpackage

// File: rtl/motion_timer.sv
// Loadable saturating up-counter with a selectable terminal count (door stroke or pump time).
// tc is high while running and sitting on the terminal value.
module motion_timer #(
   parameter int unsigned DOOR_CYCLES = 25_000_000,
   parameter int unsigned PUMP_CYCLES = 100_000_000,
   parameter int unsigned CNT_W       = 27
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic run,
   input  logic sel_pump,
   output logic tc
);

   localparam logic [CNT_W-1:0] DOOR_TERM = CNT_W'(DOOR_CYCLES - 1);
   localparam logic [CNT_W-1:0] PUMP_TERM = CNT_W'(PUMP_CYCLES - 1);

   logic [CNT_W-1:0] count_q, count_d, term;
   logic             at_term;

   assign term    = sel_pump ? PUMP_TERM : DOOR_TERM;
   assign at_term = (count_q == term);
   assign tc      = run & at_term;

   // Holding at the terminal value keeps the counter from ever wrapping.
   always_comb begin
      count_d = count_q;
      if (start) begin
         count_d = '0;
      end else if (run && !at_term) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/lock_actuator.sv
// Airlock lock actuator: models the two doors and the chamber pump, acting once per new
// command from the interlock and refusing any command that would breach the airlock.
module lock_actuator
   import airlock_pkg::*;
#(
   parameter int unsigned DOOR_CYCLES = 25_000_000,
   parameter int unsigned PUMP_CYCLES = 100_000_000,
   parameter int unsigned CNT_W       = 27
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] doorCommand,
   output logic [1:0] doors,
   output logic       pressurize,
   output logic       depressurize,
   output logic       busy,
   output logic       reject,
   output logic       done
);

   act_state_e state_q, state_d;
   logic [2:0] last_cmd_q, last_cmd_d;
   logic [1:0] doors_q, doors_d;
   logic       press_q, press_d;
   logic       depress_q, depress_d;
   logic       reject_q, reject_d;
   logic       done_q, done_d;
   logic       is_new, start, run, sel_pump, tc;

   assign is_new   = (state_q == StIdle) && (doorCommand != last_cmd_q) &&
                     (doorCommand != DOOR_COMMAND_IDLE);
   assign run      = (state_q != StIdle);
   assign sel_pump = (state_q == StPumpDown) || (state_q == StPumpUp);

   motion_timer #(
      .DOOR_CYCLES (DOOR_CYCLES),
      .PUMP_CYCLES (PUMP_CYCLES),
      .CNT_W       (CNT_W)
   ) u_motion_timer (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .run      (run),
      .sel_pump (sel_pump),
      .tc       (tc)
   );

   always_comb begin
      state_d    = state_q;
      last_cmd_d = last_cmd_q;
      doors_d    = doors_q;
      press_d    = press_q;
      depress_d  = depress_q;
      reject_d   = 1'b0;
      done_d     = 1'b0;
      start      = 1'b0;

      if (state_q == StIdle) begin
         // Commands are edge-qualified: tracking the level only while idle means changes
         // seen during a motion are re-evaluated once the motion finishes.
         last_cmd_d = doorCommand;
         if (is_new) begin
            case (doorCommand)
               DOOR_COMMAND_CLOSE_INNER: begin
                  if (!doors_q[0]) begin
                     done_d = 1'b1;
                  end else begin
                     state_d = StInnerClosing;
                     start   = 1'b1;
                  end
               end
               DOOR_COMMAND_OPEN_INNER: begin
                  if (doors_q[1] || !press_q) begin
                     reject_d = 1'b1;
                  end else if (doors_q[0]) begin
                     done_d = 1'b1;
                  end else begin
                     state_d    = StInnerOpening;
                     start      = 1'b1;
                     doors_d[0] = 1'b1;
                  end
               end
               DOOR_COMMAND_CLOSE_OUTER: begin
                  if (!doors_q[1]) begin
                     done_d = 1'b1;
                  end else begin
                     state_d = StOuterClosing;
                     start   = 1'b1;
                  end
               end
               DOOR_COMMAND_OPEN_OUTER: begin
                  if (doors_q[0] || !depress_q) begin
                     reject_d = 1'b1;
                  end else if (doors_q[1]) begin
                     done_d = 1'b1;
                  end else begin
                     state_d    = StOuterOpening;
                     start      = 1'b1;
                     doors_d[1] = 1'b1;
                  end
               end
               DOOR_COMMAND_DEPRESSURIZE: begin
                  if (doors_q != DOORS_CLOSED) begin
                     reject_d = 1'b1;
                  end else if (depress_q) begin
                     done_d = 1'b1;
                  end else begin
                     state_d = StPumpDown;
                     start   = 1'b1;
                     press_d = 1'b0;
                  end
               end
               DOOR_COMMAND_PRESSURIZE: begin
                  if (doors_q != DOORS_CLOSED) begin
                     reject_d = 1'b1;
                  end else if (press_q) begin
                     done_d = 1'b1;
                  end else begin
                     state_d   = StPumpUp;
                     start     = 1'b1;
                     depress_d = 1'b0;
                  end
               end
               default: reject_d = 1'b1;
            endcase
         end
      end else if (tc) begin
         state_d = StIdle;
         done_d  = 1'b1;
         case (state_q)
            StInnerClosing: doors_d[0] = 1'b0;
            StOuterClosing: doors_d[1] = 1'b0;
            StPumpDown:     depress_d  = 1'b1;
            StPumpUp:       press_d    = 1'b1;
            default:        ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         last_cmd_q <= DOOR_COMMAND_IDLE;
         doors_q    <= DOORS_CLOSED;
         press_q    <= 1'b1;
         depress_q  <= 1'b0;
         reject_q   <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_cmd_q <= last_cmd_d;
         doors_q    <= doors_d;
         press_q    <= press_d;
         depress_q  <= depress_d;
         reject_q   <= reject_d;
         done_q     <= done_d;
      end
   end

   assign doors        = doors_q;
   assign pressurize   = press_q;
   assign depressurize = depress_q;
   assign busy         = run;
   assign reject       = reject_q;
   assign done         = done_q;

endmodule
